// File: rtl/pe_packet_broadcaster_pkg.sv
// Shared types and per-mode packet counts for the PE broadcast bus, so the broadcaster and the
// PEs agree on packet numbering.
package pe_packet_broadcaster_pkg;

    localparam int unsigned PE_NUM_ROWS    = 4;
    localparam int unsigned PE_MAX_IFMAP   = 16;
    localparam int unsigned PE_DATA_W      = 32;
    localparam int unsigned PE_IDX_W       = $clog2(PE_MAX_IFMAP);

    localparam int unsigned L1_FILTER_SIZE = 3;
    localparam int unsigned L2_FILTER_SIZE = 5;
    localparam int unsigned L3_FILTER_SIZE = 7;
    localparam int unsigned L4_FILTER_SIZE = 3;

    typedef enum logic [1:0] {Mode1, Mode2, Mode3, Mode4} op_mode_e;
    typedef enum logic [1:0] {StageIdle, StageLoadFilter, StageConv} op_stage_e;

    typedef logic [PE_DATA_W-1:0] pe_packet_data_t;

    typedef struct packed {
        logic                  valid;
        logic [PE_IDX_W-1:0]   packet_idx;
        pe_packet_data_t       data;
    } pe_in_packet_t;

    typedef struct packed {
        op_stage_e             stage;
        logic [PE_IDX_W-1:0]   idx;
        pe_packet_data_t       data;
    } bcast_entry_t;

    function automatic int unsigned filter_pkts(op_mode_e mode, int unsigned num_rows);
        return (mode == Mode4) ? 32'd3 : num_rows;
    endfunction

    // Ifmap rows needed per window: filter height plus the extra rows the PE column slides over.
    function automatic int unsigned ifmap_pkts(op_mode_e mode);
        case (mode)
            Mode1:   return L1_FILTER_SIZE + PE_NUM_ROWS - 1;
            Mode2:   return L2_FILTER_SIZE + PE_NUM_ROWS - 1;
            Mode3:   return L3_FILTER_SIZE + PE_NUM_ROWS - 1;
            default: return L4_FILTER_SIZE + 3 - 1;
        endcase
    endfunction

endpackage

// File: rtl/pe_bcast_skid.sv
// One-entry skid buffer between the buffer read port and the PE broadcast bus; a presented packet
// is frozen while hold is high and released in order once hold drops.
module pe_bcast_skid
    import pe_packet_broadcaster_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  bcast_entry_t in_entry_i,
    input  logic         hold_i,
    output logic         out_valid_o,
    output bcast_entry_t out_entry_o
);

    logic         skid_valid_q;
    bcast_entry_t skid_q;

    // A new read is only issued when hold is low, so the skid entry and a returning read never
    // coexist; the skid simply takes priority.
    assign out_valid_o = skid_valid_q | in_valid_i;
    assign out_entry_o = skid_valid_q ? skid_q : in_entry_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= out_valid_o & hold_i;
            if (out_valid_o && hold_i) begin
                skid_q <= out_entry_o;
            end
        end
    end

endmodule

// File: rtl/pe_packet_broadcaster.sv
// Reads filter rows then ifmap windows from the global buffer and broadcasts them to the PE
// array as indexed packets, honouring PE-array backpressure.
module pe_packet_broadcaster
    import pe_packet_broadcaster_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned NUM_ROWS  = PE_NUM_ROWS,
    parameter int unsigned MAX_IFMAP = PE_MAX_IFMAP
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  op_mode_e          mode_i,
    input  logic              change_mode_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] filt_base_i,
    input  logic [ADDR_W-1:0] ifmap_base_i,
    input  logic [15:0]       num_windows_i,
    input  logic              hold_i,
    output logic              buf_rd_en_o,
    output logic [ADDR_W-1:0] buf_rd_addr_o,
    input  pe_packet_data_t   buf_rd_data_i,
    output pe_in_packet_t     pe_packet_o,
    output op_stage_e         op_stage_o,
    output logic              done_o
);

    localparam int unsigned CntW = $clog2(MAX_IFMAP + 1);

    typedef enum logic [2:0] {StIdle, StLoadFilter, StConv, StDrain, StDone} state_e;

    state_e              state_q;
    op_mode_e            cur_mode_q;
    op_stage_e           stage_q;
    logic                done_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ifmap_base_q;
    logic [CntW-1:0]     pkt_q;
    logic [15:0]         win_q;
    logic [15:0]         last_win_q;
    logic                infl_valid_q;
    logic [PE_IDX_W-1:0] infl_idx_q;
    op_stage_e           infl_stage_q;

    logic         rd_issue;
    logic         last_filt;
    logic         last_in_win;
    bcast_entry_t in_entry;
    logic         out_valid;
    bcast_entry_t out_entry;

    assign rd_issue    = ((state_q == StLoadFilter) || (state_q == StConv)) && !hold_i && !rst_i;
    assign last_filt   = (pkt_q == CntW'(filter_pkts(cur_mode_q, NUM_ROWS) - 1));
    assign last_in_win = (pkt_q == CntW'(ifmap_pkts(cur_mode_q) - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cur_mode_q   <= Mode1;
            stage_q      <= StageIdle;
            done_q       <= 1'b0;
            ptr_q        <= '0;
            ifmap_base_q <= '0;
            pkt_q        <= '0;
            win_q        <= '0;
            last_win_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (change_mode_i) begin
                        cur_mode_q <= mode_i;
                    end
                    if (start_i) begin
                        state_q      <= StLoadFilter;
                        stage_q      <= StageLoadFilter;
                        ptr_q        <= filt_base_i;
                        ifmap_base_q <= ifmap_base_i;
                        pkt_q        <= '0;
                        win_q        <= '0;
                        last_win_q   <= (num_windows_i == 16'd0) ? 16'd0 : num_windows_i - 16'd1;
                    end
                end
                StLoadFilter: begin
                    if (rd_issue) begin
                        if (last_filt) begin
                            state_q <= StConv;
                            stage_q <= StageConv;
                            ptr_q   <= ifmap_base_q;
                            pkt_q   <= '0;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                            pkt_q <= pkt_q + 1'b1;
                        end
                    end
                end
                StConv: begin
                    // Windows are laid out back to back, so a running pointer covers base+w*I+j.
                    if (rd_issue) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (last_in_win) begin
                            pkt_q <= '0;
                            win_q <= win_q + 16'd1;
                            if (win_q == last_win_q) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            pkt_q <= pkt_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_valid && !hold_i) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    stage_q <= StageIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag each read with its index and stage so the packet stays self-describing through the skid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_valid_q <= 1'b0;
            infl_idx_q   <= '0;
            infl_stage_q <= StageIdle;
        end else begin
            infl_valid_q <= rd_issue;
            if (rd_issue) begin
                infl_idx_q   <= pkt_q[PE_IDX_W-1:0];
                infl_stage_q <= (state_q == StLoadFilter) ? StageLoadFilter : StageConv;
            end
        end
    end

    assign in_entry = '{stage: infl_stage_q, idx: infl_idx_q, data: buf_rd_data_i};

    pe_bcast_skid u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (infl_valid_q),
        .in_entry_i  (in_entry),
        .hold_i      (hold_i),
        .out_valid_o (out_valid),
        .out_entry_o (out_entry)
    );

    assign buf_rd_en_o   = rd_issue;
    assign buf_rd_addr_o = ptr_q;
    assign pe_packet_o   = '{valid:      out_valid,
                             packet_idx: out_entry.idx,
                             data:       out_valid ? out_entry.data : '0};
    assign op_stage_o    = out_valid ? out_entry.stage : stage_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_pe_packet_broadcaster.sv
// Directed passes with random buffer contents and hold patterns, checked against a packet-list
// model built from the mode's filter/ifmap counts and the buffer image.
module tb_pe_packet_broadcaster;
    import pe_packet_broadcaster_pkg::*;

    localparam int unsigned AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    op_mode_e          mode;
    logic              change_mode;
    logic              start;
    logic [AW-1:0]     filt_base;
    logic [AW-1:0]     ifmap_base;
    logic [15:0]       num_windows;
    logic              hold;
    logic              buf_rd_en;
    logic [AW-1:0]     buf_rd_addr;
    pe_packet_data_t   buf_rd_data;
    pe_in_packet_t     pe_packet;
    op_stage_e         op_stage;
    logic              done;

    pe_packet_data_t   mem [1 << AW];
    int                n_checks = 0;
    int                n_fail = 0;
    op_mode_e          model_mode;
    int                filt_tbl  [4] = '{4, 4, 4, 3};
    int                ifmap_tbl [4] = '{6, 8, 10, 5};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    pe_packet_broadcaster #(.ADDR_W(AW), .NUM_ROWS(4), .MAX_IFMAP(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mode_i        (mode),
        .change_mode_i (change_mode),
        .start_i       (start),
        .filt_base_i   (filt_base),
        .ifmap_base_i  (ifmap_base),
        .num_windows_i (num_windows),
        .hold_i        (hold),
        .buf_rd_en_o   (buf_rd_en),
        .buf_rd_addr_o (buf_rd_addr),
        .buf_rd_data_i (buf_rd_data),
        .pe_packet_o   (pe_packet),
        .op_stage_o    (op_stage),
        .done_o        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic hold_for(input int cyc, input int pct, input int at);
        return ((at >= 0) && (cyc >= at) && (cyc < at + 3)) || ($urandom_range(99) < pct);
    endfunction

    task automatic run_pass(input bit set_mode, input op_mode_e m, input int nw,
                            input int hold_pct, input int hold_at, input int poke_at);
        logic [AW-1:0]   fb, ib, a;
        logic [AW-1:0]   exp_addr [$];
        int              exp_idx [$];
        pe_packet_data_t exp_data [$];
        op_stage_e       exp_stage [$];
        int              nwin, total, cyc, budget, n_acc, last_acc;
        bit              seen_done, seen_valid, prev_held, steady;
        pe_in_packet_t   prev_pkt;
        op_stage_e       prev_stage;

        fb = AW'($urandom);
        ib = AW'($urandom);
        if (set_mode) begin
            @(posedge clk); #1;
            mode = m;
            change_mode = 1'b1;
            @(posedge clk); #1;
            change_mode = 1'b0;
            mode = op_mode_e'(2'($urandom));
            model_mode = m;
        end
        nwin = (nw == 0) ? 1 : nw;
        for (int k = 0; k < filt_tbl[model_mode]; k++) begin
            a = fb + AW'(k);
            exp_addr.push_back(a);
            exp_idx.push_back(k);
            exp_data.push_back(mem[a]);
            exp_stage.push_back(StageLoadFilter);
        end
        for (int w = 0; w < nwin; w++) begin
            for (int j = 0; j < ifmap_tbl[model_mode]; j++) begin
                a = ib + AW'(w * ifmap_tbl[model_mode] + j);
                exp_addr.push_back(a);
                exp_idx.push_back(j);
                exp_data.push_back(mem[a]);
                exp_stage.push_back(StageConv);
            end
        end
        total = exp_idx.size();
        budget = 20 + total * 10;
        steady = (hold_pct == 0);
        n_acc = 0;
        last_acc = -10;
        seen_done = 1'b0;
        seen_valid = 1'b0;
        prev_held = 1'b0;

        @(posedge clk); #1;
        start = 1'b1;
        filt_base = fb;
        ifmap_base = ib;
        num_windows = 16'(nw);
        @(posedge clk); #1;
        start = 1'b0;
        hold = hold_for(1, hold_pct, hold_at);
        cyc = 1;
        while (cyc <= budget && !seen_done) begin
            @(negedge clk);
            if (cyc == 1 && steady && !hold) chk("first_rd", buf_rd_en, 1);
            if (buf_rd_en) begin
                chk("rd_during_hold", hold, 0);
                if (exp_addr.size() == 0) chk("extra_read", buf_rd_addr, 'x);
                else chk("rd_addr", buf_rd_addr, exp_addr.pop_front());
            end
            if (prev_held) chk("held_pkt", {pe_packet, op_stage}, {prev_pkt, prev_stage});
            if (pe_packet.valid) seen_valid = 1'b1;
            else if (steady && seen_valid && n_acc < total) chk("stream_gap", pe_packet.valid, 1);
            if (pe_packet.valid && !hold) begin
                if (exp_idx.size() == 0) begin
                    chk("extra_pkt", n_acc, total - 1);
                end else begin
                    chk("pkt_idx", pe_packet.packet_idx, exp_idx.pop_front());
                    chk("pkt_data", pe_packet.data, exp_data.pop_front());
                    chk("pkt_stage", op_stage, exp_stage.pop_front());
                end
                n_acc++;
                last_acc = cyc;
            end
            if (done) begin
                chk("done_timing", cyc, last_acc + 1);
                chk("done_count", n_acc, total);
                chk("done_stage", op_stage, StageConv);
                seen_done = 1'b1;
            end
            prev_held = pe_packet.valid && hold;
            prev_pkt = pe_packet;
            prev_stage = op_stage;
            @(posedge clk); #1;
            cyc++;
            hold = hold_for(cyc, hold_pct, hold_at);
            start = (cyc == poke_at);
            change_mode = start;
            if (start) begin
                mode = (model_mode == Mode3) ? Mode2 : Mode3;
                filt_base = AW'($urandom);
            end
        end
        if (!seen_done) chk("done_timeout", cyc, budget + 1);
        hold = 1'b0;
        start = 1'b0;
        change_mode = 1'b0;
        @(negedge clk);
        chk("post_stage", op_stage, StageIdle);
        chk("post_valid", pe_packet.valid, 0);
        chk("post_done", done, 0);
        chk("reads_left", exp_addr.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        rst = 1'b1;
        mode = Mode1;
        change_mode = 1'b0;
        start = 1'b0;
        filt_base = '0;
        ifmap_base = '0;
        num_windows = '0;
        hold = 1'b0;
        model_mode = Mode1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pkt", pe_packet, 0);
        chk("rst_stage", op_stage, StageIdle);
        chk("rst_rd_en", buf_rd_en, 0);
        chk("rst_done", done, 0);

        run_pass(1'b1, Mode1, 1, 0, -1, -1);
        run_pass(1'b1, Mode4, 2, 0, -1, -1);
        run_pass(1'b1, Mode2, 2, 0, 12, -1);
        run_pass(1'b1, Mode3, 3, 0, -1, -1);
        run_pass(1'b1, Mode2, 2, 30, -1, -1);
        run_pass(1'b0, Mode2, 0, 40, -1, -1);
        run_pass(1'b1, Mode1, 2, 0, -1, 10);
        run_pass(1'b0, Mode1, 1, 0, -1, -1);

        // Abort mid-CONV, then confirm a clean restart in the reset mode.
        run_pass(1'b1, Mode3, 1, 0, -1, -1);
        @(posedge clk); #1;
        start = 1'b1;
        num_windows = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_mode = Mode1;
        @(negedge clk);
        chk("abort_stage", op_stage, StageIdle);
        chk("abort_valid", pe_packet.valid, 0);
        chk("abort_rd_en", buf_rd_en, 0);
        chk("abort_done", done, 0);
        run_pass(1'b0, Mode1, 2, 20, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
